// File: rtl/sd_block_read_engine.sv
// -----------------------------------------------------------------------------
// sd_block_read_engine
//
// Multi-block SD card read data path. It waits for a start bit on all DAT
// lanes, deserialises one block of LANES bits per sdClk (MSB first, highest
// lane carries the highest bit), and packs the bits into WORD_W-bit words for
// the read FIFO. It then checks one CRC16 per lane and the end bit, and counts
// the blocks that arrive with a good CRC. Between blocks it can ask for the
// card clock to be stopped while the read FIFO is almost full.
//
// Ports
//   sdClk              in   free-running data-path clock
//   sysRstN            in   asynchronous active-low reset
//   readCmd            in   one-cycle start pulse, ignored while busy
//   blockCount         in   number of blocks to read, sampled on readCmd
//   sdDataIn           in   DAT[LANES-1:0] from the pads
//   readFifoAlmostFull in   read FIFO programmable-full flag
//   readDataOut        out  packed word, valid while readFifoWe is high
//   readFifoWe         out  one-cycle write strobe to the read FIFO
//   readDone           out  one-cycle pulse at the end of a transfer
//   crcErr             out  sticky CRC / end-bit error flag
//   timeOut            out  sticky start-bit timeout flag
//   sdClkStop          out  card clock stop request (block boundary only)
//   busy               out  transfer in progress, drops the cycle after readDone
//   blocksDone         out  blocks received with good CRC in this transfer
// -----------------------------------------------------------------------------
module sd_block_read_engine #(
   parameter int LANES       = 4,
   parameter int BLOCK_BYTES = 512,
   parameter int WORD_W      = 64,
   parameter int TIMEOUT     = 65535
) (
   input  logic              sdClk,
   input  logic              sysRstN,
   input  logic              readCmd,
   input  logic [15:0]       blockCount,
   input  logic [LANES-1:0]  sdDataIn,
   input  logic              readFifoAlmostFull,
   output logic [WORD_W-1:0] readDataOut,
   output logic              readFifoWe,
   output logic              readDone,
   output logic              crcErr,
   output logic              timeOut,
   output logic              sdClkStop,
   output logic              busy,
   output logic [15:0]       blocksDone
);

   localparam int DATA_CYCLES     = BLOCK_BYTES * 8 / LANES;
   localparam int SHIFTS_PER_WORD = WORD_W / LANES;
   localparam int DCNT_W = (DATA_CYCLES > 1) ? $clog2(DATA_CYCLES) : 1;
   localparam int WCNT_W = (SHIFTS_PER_WORD > 1) ? $clog2(SHIFTS_PER_WORD) : 1;
   localparam int TMR_W  = 20;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_ST,
      DATA,
      CRC,
      END,
      GAP,
      DONE
   } stateT;

   stateT                   state, nextState;
   logic [TMR_W-1:0]        timer;
   logic [DCNT_W-1:0]       dataCnt;
   logic [WCNT_W-1:0]       wordCnt;
   logic [3:0]              crcCnt;
   logic [LANES-1:0][15:0]  crcReg;
   logic                    crcBad;
   logic [15:0]             blockTarget;
   logic [WORD_W-1:0]       shifted;

   // FSM decode strobes
   logic accept;
   logic setTimeOut;
   logic setCrcErr;
   logic blockGood;

   // One step of x^16 + x^12 + x^5 + 1, MSB first.
   function automatic logic [15:0] crc16Step(input logic [15:0] crc, input logic bitIn);
      logic fb;
      // NOTE: blocking assignments are right inside a function (pure combinational scope); registers below use <= only.
      fb = crc[15] ^ bitIn;
      crc16Step = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   // --------------------------------------------------------------------------
   // Word packing. The partial word holds the groups already received for the
   // current word; "shifted" is that partial word with this cycle's lanes
   // appended, so it is the finished word on the last shift of a word.
   // --------------------------------------------------------------------------
   generate
      if (WORD_W > LANES) begin : gPack
         logic [WORD_W-LANES-1:0] partial;

         assign shifted = {partial, sdDataIn};

         always_ff @(posedge sdClk or negedge sysRstN) begin
            if (!sysRstN) begin
               partial <= '0;
            end else if (state == DATA) begin
               partial <= shifted[WORD_W-LANES-1:0];
            end
         end
      end else begin : gNoPack
         assign shifted = sdDataIn;
      end
   endgenerate

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no latch is inferred.
      nextState  = state;
      accept     = 1'b0;
      setTimeOut = 1'b0;
      setCrcErr  = 1'b0;
      blockGood  = 1'b0;

      case (state)
         IDLE: begin
            // busy is still high in the readDone cycle, so a command there is dropped
            if (readCmd && !busy) begin
               accept    = 1'b1;
               nextState = (blockCount == 16'd0) ? DONE : WAIT_ST;
            end
         end

         WAIT_ST: begin
            if (sdDataIn == '0) begin
               nextState = DATA;
            end else if (timer == TMR_W'(TIMEOUT - 1)) begin
               setTimeOut = 1'b1;
               nextState  = DONE;
            end
         end

         DATA: begin
            if (dataCnt == DCNT_W'(DATA_CYCLES - 1)) begin
               nextState = CRC;
            end
         end

         CRC: begin
            if (crcCnt == 4'd15) begin
               nextState = END;
            end
         end

         END: begin
            if (!(&sdDataIn) || crcBad) begin
               setCrcErr = 1'b1;
               nextState = DONE;
            end else begin
               blockGood = 1'b1;
               nextState = ((blocksDone + 16'd1) == blockTarget) ? DONE : GAP;
            end
         end

         GAP: begin
            if (!readFifoAlmostFull) begin
               nextState = WAIT_ST;
            end
         end

         DONE: begin
            nextState = IDLE;
         end

         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Clock stop is only ever requested between blocks and follows the FIFO
   // flag combinationally, so it releases in the same cycle almostFull falls.
   assign sdClkStop = (state == GAP) && readFifoAlmostFull;

   // --------------------------------------------------------------------------
   // State register and data path
   // --------------------------------------------------------------------------
   always_ff @(posedge sdClk or negedge sysRstN) begin
      if (!sysRstN) begin
         state       <= IDLE;
         timer       <= '0;
         dataCnt     <= '0;
         wordCnt     <= '0;
         crcCnt      <= '0;
         // NOTE: the per-lane CRC array is a handful of flops, not a RAM, so it is reset with everything else.
         crcReg      <= '0;
         crcBad      <= 1'b0;
         blockTarget <= '0;
         readDataOut <= '0;
         readFifoWe  <= 1'b0;
         readDone    <= 1'b0;
         crcErr      <= 1'b0;
         timeOut     <= 1'b0;
         busy        <= 1'b0;
         blocksDone  <= '0;
      end else begin
         state      <= nextState;
         readFifoWe <= 1'b0;
         readDone   <= (state == DONE);
         busy       <= (nextState != IDLE) || (state == DONE);

         if (accept) begin
            blockTarget <= blockCount;
            crcErr      <= 1'b0;
            timeOut     <= 1'b0;
            blocksDone  <= '0;
         end
         if (setTimeOut) begin
            timeOut <= 1'b1;
         end
         if (setCrcErr) begin
            crcErr <= 1'b1;
         end
         if (blockGood) begin
            blocksDone <= blocksDone + 16'd1;
         end

         // Start-bit timer: cleared on every entry to WAIT_ST, counts only
         // there (frozen in GAP), saturates at TIMEOUT.
         if ((state != WAIT_ST) && (nextState == WAIT_ST)) begin
            timer <= '0;
         end else if ((state == WAIT_ST) && (timer != TMR_W'(TIMEOUT))) begin
            timer <= timer + 1'b1;
         end

         case (state)
            WAIT_ST: begin
               if (nextState == DATA) begin
                  dataCnt <= '0;
                  wordCnt <= '0;
                  crcCnt  <= '0;
                  crcReg  <= '0;
                  crcBad  <= 1'b0;
               end
            end

            DATA: begin
               dataCnt <= dataCnt + 1'b1;
               for (int l = 0; l < LANES; l++) begin
                  crcReg[l] <= crc16Step(crcReg[l], sdDataIn[l]);
               end
               // Writes are not gated by almostFull here: the FIFO's
               // programmable-full margin is sized to absorb a whole block.
               if (wordCnt == WCNT_W'(SHIFTS_PER_WORD - 1)) begin
                  wordCnt     <= '0;
                  readDataOut <= shifted;
                  readFifoWe  <= 1'b1;
               end else begin
                  wordCnt <= wordCnt + 1'b1;
               end
            end

            CRC: begin
               crcCnt <= crcCnt + 1'b1;
               // Each lane's computed CRC is shifted out MSB first and
               // compared bit by bit with what the card sends on that lane.
               for (int l = 0; l < LANES; l++) begin
                  if (sdDataIn[l] != crcReg[l][15]) begin
                     crcBad <= 1'b1;
                  end
                  crcReg[l] <= {crcReg[l][14:0], 1'b0};
               end
            end

            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_block_read_engine.sv
// -----------------------------------------------------------------------------
// tb_sd_block_read_engine
//
// Directed bench for sd_block_read_engine. Three instances (1, 4 and 8 lanes,
// 64-bit words, 512-byte blocks, start-bit timeout of 100 cycles) share one
// 8-bit DAT bus; only the instance that was sent a readCmd is active. Block
// payload is bytes 0x00..0xFF twice; CRCs sent by the bench are computed from
// the bits it drives on each lane.
// -----------------------------------------------------------------------------
module tb_sd_block_read_engine;

   logic        sdClk = 1'b0;
   logic        sysRstN;
   logic [15:0] blockCount;
   logic [7:0]  dat;
   logic        af;
   logic        cmd1, cmd4, cmd8;

   logic [63:0] rd1, rd4, rd8;
   logic        we1, we4, we8;
   logic        done1, done4, done8;
   logic        crc1, crc4, crc8;
   logic        to1, to4, to8;
   logic        stop1, stop4, stop8;
   logic        busy1, busy4, busy8;
   logic [15:0] bd1, bd4, bd8;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [63:0] q1[$];
   logic [63:0] q4[$];
   logic [63:0] q8[$];
   int          done4Cnt = 0;
   int          stop4Cnt = 0;

   always #5 sdClk = ~sdClk;

   sd_block_read_engine #(.LANES(1), .BLOCK_BYTES(512), .WORD_W(64), .TIMEOUT(100)) dut1 (
      .sdClk(sdClk), .sysRstN(sysRstN), .readCmd(cmd1), .blockCount(blockCount),
      .sdDataIn(dat[0:0]), .readFifoAlmostFull(af), .readDataOut(rd1), .readFifoWe(we1),
      .readDone(done1), .crcErr(crc1), .timeOut(to1), .sdClkStop(stop1), .busy(busy1),
      .blocksDone(bd1));

   sd_block_read_engine #(.LANES(4), .BLOCK_BYTES(512), .WORD_W(64), .TIMEOUT(100)) dut4 (
      .sdClk(sdClk), .sysRstN(sysRstN), .readCmd(cmd4), .blockCount(blockCount),
      .sdDataIn(dat[3:0]), .readFifoAlmostFull(af), .readDataOut(rd4), .readFifoWe(we4),
      .readDone(done4), .crcErr(crc4), .timeOut(to4), .sdClkStop(stop4), .busy(busy4),
      .blocksDone(bd4));

   sd_block_read_engine #(.LANES(8), .BLOCK_BYTES(512), .WORD_W(64), .TIMEOUT(100)) dut8 (
      .sdClk(sdClk), .sysRstN(sysRstN), .readCmd(cmd8), .blockCount(blockCount),
      .sdDataIn(dat), .readFifoAlmostFull(af), .readDataOut(rd8), .readFifoWe(we8),
      .readDone(done8), .crcErr(crc8), .timeOut(to8), .sdClkStop(stop8), .busy(busy8),
      .blocksDone(bd8));

   // Output monitors, sampled on the falling edge.
   always @(negedge sdClk) begin
      if (we1) q1.push_back(rd1);
      if (we4) q4.push_back(rd4);
      if (we8) q8.push_back(rd8);
      if (done4) done4Cnt++;
      if (stop4) stop4Cnt++;
   end

   // Expected j-th 64-bit word of the block: bytes 8j..8j+7 (mod 256), first byte on top.
   function automatic logic [63:0] expWord(input int j);
      logic [63:0] w;
      w = '0;
      for (int b = 0; b < 8; b++) begin
         w = {w[55:0], 8'(j * 8 + b)};
      end
      return w;
   endfunction

   function automatic logic [15:0] crcBit(input logic [15:0] c, input logic d);
      return (c << 1) ^ ((c[15] ^ d) ? 16'h1021 : 16'h0000);
   endfunction

   // Drive one DAT value for one sdClk cycle; entered and left at posedge+1.
   task automatic sendCycle(input logic [7:0] v);
      dat = v;
      @(posedge sdClk);
      #1;
   endtask

   task automatic pulseCmd(input int sel, input logic [15:0] count);
      @(posedge sdClk);
      #1;
      blockCount = count;
      case (sel)
         1:       cmd1 = 1'b1;
         4:       cmd4 = 1'b1;
         default: cmd8 = 1'b1;
      endcase
      @(posedge sdClk);
      #1;
      cmd1 = 1'b0;
      cmd4 = 1'b0;
      cmd8 = 1'b0;
   endtask

   // Start bit, 4096/lanes data cycles, per-lane CRC16 (optionally one bit
   // inverted), end bit. flipLane < 0 means no corruption.
   task automatic sendBlock(input int lanes, input int flipLane, input int flipBit);
      logic [15:0] lc [8];
      logic [7:0]  v;
      logic [7:0]  b;
      int          k;
      for (int l = 0; l < 8; l++) lc[l] = 16'h0000;
      sendCycle(8'h00);
      for (int c = 0; c < 4096 / lanes; c++) begin
         v = 8'hFF;
         for (int l = 0; l < lanes; l++) begin
            k     = c * lanes + (lanes - 1 - l);
            b     = 8'(k / 8);
            v[l]  = b[7 - (k % 8)];
            lc[l] = crcBit(lc[l], v[l]);
         end
         sendCycle(v);
      end
      for (int i = 15; i >= 0; i--) begin
         v = 8'hFF;
         for (int l = 0; l < lanes; l++) begin
            v[l] = lc[l][i];
            if (l == flipLane && i == flipBit) v[l] = ~v[l];
         end
         sendCycle(v);
      end
      sendCycle(8'hFF);
   endtask

   // Bounded wait for readDone of the selected instance (returns at a negedge).
   task automatic waitDone(input int sel, input int maxCycles, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < maxCycles && !seen; i++) begin
         @(negedge sdClk);
         case (sel)
            1:       seen = done1;
            4:       seen = done4;
            default: seen = done8;
         endcase
      end
   endtask

   task automatic test_reset;
      sysRstN = 1'b0;
      repeat (2) @(negedge sdClk);
      testsRun++;
      if ({rd4, we4, done4, crc4, to4, stop4, busy4, bd4} !== '0) begin
         testsFailed++;
         $display("FAIL reset_dut4: outputs got %h expected 0", {rd4, we4, done4, crc4, to4, stop4, busy4, bd4});
      end
      testsRun++;
      if ({rd1, we1, done1, busy1, bd1, rd8, we8, done8, busy8, bd8} !== '0) begin
         testsFailed++;
         $display("FAIL reset_dut1_dut8: outputs not all zero");
      end
      @(posedge sdClk);
      #1;
      sysRstN = 1'b1;
   endtask

   task automatic test_single_block;
      bit seen;
      int bad;
      logic [63:0] first;
      q4.delete();
      pulseCmd(4, 16'd1);
      sendBlock(4, -1, 0);
      waitDone(4, 50, seen);
      testsRun++;
      if (seen !== 1'b1) begin testsFailed++; $display("FAIL t1_done: readDone got %0d expected 1", seen); end
      testsRun++;
      if (q4.size() !== 64) begin testsFailed++; $display("FAIL t1_wordCount: got %0d expected 64", q4.size()); end
      first = (q4.size() > 0) ? q4[0] : 64'hx;
      testsRun++;
      if (first !== 64'h0001020304050607) begin testsFailed++; $display("FAIL t1_firstWord: got %h expected 0001020304050607", first); end
      bad = 0;
      foreach (q4[j]) if (q4[j] !== expWord(j % 64)) bad++;
      testsRun++;
      if (bad !== 0) begin testsFailed++; $display("FAIL t1_words: %0d wrong words, expected 0", bad); end
      testsRun++;
      if ({crc4, to4} !== 2'b00) begin testsFailed++; $display("FAIL t1_flags: crcErr,timeOut got %b expected 00", {crc4, to4}); end
      testsRun++;
      if (bd4 !== 16'd1) begin testsFailed++; $display("FAIL t1_blocksDone: got %0d expected 1", bd4); end
      testsRun++;
      if (busy4 !== 1'b1) begin testsFailed++; $display("FAIL t1_busyAtDone: got %b expected 1", busy4); end
      @(negedge sdClk);
      testsRun++;
      if ({busy4, done4} !== 2'b00) begin testsFailed++; $display("FAIL t1_busyAfter: busy,readDone got %b expected 00", {busy4, done4}); end
   endtask

   task automatic test_crc_error;
      bit seen;
      q4.delete();
      pulseCmd(4, 16'd1);
      sendBlock(4, 2, 3);
      waitDone(4, 50, seen);
      testsRun++;
      if (seen !== 1'b1) begin testsFailed++; $display("FAIL t2_done: readDone got %0d expected 1", seen); end
      testsRun++;
      if ({crc4, to4} !== 2'b10) begin testsFailed++; $display("FAIL t2_flags: crcErr,timeOut got %b expected 10", {crc4, to4}); end
      testsRun++;
      if (bd4 !== 16'd0) begin testsFailed++; $display("FAIL t2_blocksDone: got %0d expected 0", bd4); end
      testsRun++;
      if (q4.size() !== 64) begin testsFailed++; $display("FAIL t2_wordCount: got %0d expected 64", q4.size()); end
   endtask

   task automatic test_timeout;
      int k;
      bit seen;
      dat = 8'hFF;
      pulseCmd(4, 16'd1);
      k = 0;
      seen = 1'b0;
      while (k < 200 && !seen) begin
         @(posedge sdClk);
         k++;
         @(negedge sdClk);
         if (to4) seen = 1'b1;
      end
      testsRun++;
      if (k !== 100) begin testsFailed++; $display("FAIL t3_timeoutCycle: got %0d expected 100", k); end
      testsRun++;
      if ({done4, crc4} !== 2'b00) begin testsFailed++; $display("FAIL t3_atTimeout: readDone,crcErr got %b expected 00", {done4, crc4}); end
      // readCmd during the readDone cycle must be ignored (busy still high)
      @(posedge sdClk);
      #1;
      blockCount = 16'd1;
      cmd4 = 1'b1;
      @(negedge sdClk);
      testsRun++;
      if ({done4, busy4, to4} !== 3'b111) begin testsFailed++; $display("FAIL t3_doneCycle: readDone,busy,timeOut got %b expected 111", {done4, busy4, to4}); end
      @(posedge sdClk);
      #1;
      cmd4 = 1'b0;
      @(negedge sdClk);
      testsRun++;
      if ({busy4, done4, to4} !== 3'b001) begin testsFailed++; $display("FAIL t3_cmdIgnored: busy,readDone,timeOut got %b expected 001", {busy4, done4, to4}); end
   endtask

   task automatic test_zero_blocks;
      bit seen;
      q4.delete();
      pulseCmd(4, 16'd0);
      waitDone(4, 10, seen);
      testsRun++;
      if (seen !== 1'b1) begin testsFailed++; $display("FAIL zero_done: readDone got %0d expected 1", seen); end
      testsRun++;
      if ({to4, crc4, bd4} !== 18'd0) begin testsFailed++; $display("FAIL zero_state: timeOut,crcErr,blocksDone got %h expected 0", {to4, crc4, bd4}); end
      testsRun++;
      if (q4.size() !== 0) begin testsFailed++; $display("FAIL zero_words: got %0d expected 0", q4.size()); end
   endtask

   task automatic test_back_to_back;
      bit seen;
      int bad;
      q4.delete();
      stop4Cnt = 0;
      pulseCmd(4, 16'd3);
      sendBlock(4, -1, 0);
      af = 1'b1;
      repeat (50) @(posedge sdClk);
      #1;
      af = 1'b0;
      repeat (2) sendCycle(8'hFF);
      sendBlock(4, -1, 0);
      repeat (2) sendCycle(8'hFF);
      sendBlock(4, -1, 0);
      waitDone(4, 50, seen);
      testsRun++;
      if (seen !== 1'b1) begin testsFailed++; $display("FAIL t4_done: readDone got %0d expected 1", seen); end
      testsRun++;
      if (stop4Cnt !== 50) begin testsFailed++; $display("FAIL t4_clkStop: high %0d cycles expected 50", stop4Cnt); end
      testsRun++;
      if (bd4 !== 16'd3) begin testsFailed++; $display("FAIL t4_blocksDone: got %0d expected 3", bd4); end
      testsRun++;
      if (q4.size() !== 192) begin testsFailed++; $display("FAIL t4_wordCount: got %0d expected 192", q4.size()); end
      bad = 0;
      foreach (q4[j]) if (q4[j] !== expWord(j % 64)) bad++;
      testsRun++;
      if (bad !== 0) begin testsFailed++; $display("FAIL t4_words: %0d wrong words, expected 0", bad); end
      testsRun++;
      if ({crc4, to4} !== 2'b00) begin testsFailed++; $display("FAIL t4_flags: crcErr,timeOut got %b expected 00", {crc4, to4}); end
   endtask

   task automatic test_lane_widths;
      bit seen;
      int bad;
      q1.delete();
      pulseCmd(1, 16'd1);
      sendBlock(1, -1, 0);
      waitDone(1, 50, seen);
      testsRun++;
      if (seen !== 1'b1) begin testsFailed++; $display("FAIL t5_done1: readDone got %0d expected 1", seen); end
      testsRun++;
      if ({q1.size() == 64, crc1, bd1} !== {1'b1, 1'b0, 16'd1}) begin
         testsFailed++;
         $display("FAIL t5_lane1: words %0d crcErr %b blocksDone %0d expected 64 0 1", q1.size(), crc1, bd1);
      end
      bad = 0;
      foreach (q1[j]) if (q1[j] !== expWord(j)) bad++;
      testsRun++;
      if (bad !== 0) begin testsFailed++; $display("FAIL t5_words1: %0d wrong words, expected 0", bad); end

      q8.delete();
      pulseCmd(8, 16'd1);
      sendBlock(8, -1, 0);
      waitDone(8, 50, seen);
      testsRun++;
      if (seen !== 1'b1) begin testsFailed++; $display("FAIL t5_done8: readDone got %0d expected 1", seen); end
      testsRun++;
      if ({q8.size() == 64, crc8, bd8} !== {1'b1, 1'b0, 16'd1}) begin
         testsFailed++;
         $display("FAIL t5_lane8: words %0d crcErr %b blocksDone %0d expected 64 0 1", q8.size(), crc8, bd8);
      end
      bad = 0;
      foreach (q8[j]) if (q8[j] !== expWord(j)) bad++;
      testsRun++;
      if (bad !== 0) begin testsFailed++; $display("FAIL t5_words8: %0d wrong words, expected 0", bad); end
   endtask

   task automatic test_reset_mid_transfer;
      bit seen;
      int bad;
      done4Cnt = 0;
      pulseCmd(4, 16'd1);
      sendCycle(8'h00);
      repeat (100) sendCycle(8'h5A);
      sysRstN = 1'b0;
      #2;
      testsRun++;
      if ({rd4, we4, done4, crc4, to4, stop4, busy4, bd4} !== '0) begin
         testsFailed++;
         $display("FAIL t6_inReset: outputs got %h expected 0", {rd4, we4, done4, crc4, to4, stop4, busy4, bd4});
      end
      dat = 8'hFF;
      repeat (2) @(posedge sdClk);
      #1;
      sysRstN = 1'b1;
      q4.delete();
      pulseCmd(4, 16'd1);
      sendBlock(4, -1, 0);
      waitDone(4, 50, seen);
      testsRun++;
      if ({seen, crc4, bd4} !== {1'b1, 1'b0, 16'd1}) begin
         testsFailed++;
         $display("FAIL t6_after: readDone %0d crcErr %b blocksDone %0d expected 1 0 1", seen, crc4, bd4);
      end
      bad = 0;
      foreach (q4[j]) if (q4[j] !== expWord(j)) bad++;
      testsRun++;
      if (q4.size() !== 64 || bad !== 0) begin
         testsFailed++;
         $display("FAIL t6_words: got %0d words with %0d wrong, expected 64 with 0 wrong", q4.size(), bad);
      end
      @(negedge sdClk);
      testsRun++;
      if (done4Cnt !== 1) begin testsFailed++; $display("FAIL t6_doneCount: got %0d readDone pulses expected 1", done4Cnt); end
   endtask

   initial begin
      sysRstN    = 1'b0;
      blockCount = 16'd0;
      dat        = 8'hFF;
      af         = 1'b0;
      cmd1       = 1'b0;
      cmd4       = 1'b0;
      cmd8       = 1'b0;
      test_reset();
      test_single_block();
      test_crc_error();
      test_timeout();
      test_zero_blocks();
      test_back_to_back();
      test_lane_widths();
      test_reset_mid_transfer();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
